// File: rtl/add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor: mode encodings and default geometry.
// No logic, so no latency.
// No handshake, so no backpressure.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ADD_MODE_ADD = 2'b00,
        ADD_MODE_SUB = 2'b01,
        ADD_MODE_ADC = 2'b10,
        ADD_MODE_SBB = 2'b11
    } add_mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

endpackage

// File: rtl/pipe_add_sub_slice.sv
// One CHUNK-bit ripple-carry slice built from per-bit sum/carry equations.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns all flow control.
module pipe_add_sub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[CHUNK];

endmodule

// File: rtl/pipe_add_sub.sv
// Pipelined WIDTH-bit ADD/SUB/ADC/SBB, one CHUNK-bit slice per register stage, with co/ovf/zero flags.
// Latency: STAGES = WIDTH/CHUNK cycles from accept to out_valid; one beat per cycle sustained.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready is combinational from out_ready.
module pipe_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = WIDTH / CHUNK;

    if ((CHUNK < 1) || (STAGES < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $fatal(1, "pipe_add_sub: WIDTH must be a positive multiple of CHUNK");
    end

    logic              advance;
    logic              accept;
    logic [STAGES-1:0] stg_vld;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [WIDTH-1:0]  fin_sum;
    logic              fin_co;
    logic              fin_a_msb;
    logic              fin_b_msb;

    // in_ready depends combinationally on out_ready: integrators must not close a loop through it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !wb_rst_i;
    assign accept   = in_valid && in_ready;

    always_comb begin
        b_eff = in_b;
        c0    = 1'b0;
        case (add_mode_e'(in_mode))
            ADD_MODE_ADD: ;
            ADD_MODE_SUB: begin
                b_eff = ~in_b;
                c0    = 1'b1;
            end
            ADD_MODE_ADC: c0 = in_cin;
            ADD_MODE_SBB: begin
                b_eff = ~in_b;
                c0    = in_cin;
            end
            default: ;
        endcase
    end

    // Stage k consumes the low CHUNK bits of what is still pending and passes the rest upward.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - k * CHUNK;

        logic [HI-1:0]          a_cur;
        logic [HI-1:0]          b_cur;
        logic                   c_cur;
        logic [CHUNK-1:0]       sl_sum;
        logic                   sl_co;
        logic [(k+1)*CHUNK-1:0] s_done;

        if (k == 0) begin : g_src
            assign a_cur  = in_a;
            assign b_cur  = b_eff;
            assign c_cur  = c0;
            assign s_done = sl_sum;
        end else begin : g_src
            assign a_cur  = g_stage[k-1].g_reg.a_hi_r;
            assign b_cur  = g_stage[k-1].g_reg.b_hi_r;
            assign c_cur  = g_stage[k-1].g_reg.c_r;
            assign s_done = {sl_sum, g_stage[k-1].g_reg.s_lo_r};
        end

        pipe_add_sub_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a   (a_cur[CHUNK-1:0]),
            .b   (b_cur[CHUNK-1:0]),
            .cin (c_cur),
            .sum (sl_sum),
            .cout(sl_co)
        );

        if (k < STAGES - 1) begin : g_reg
            logic [HI-CHUNK-1:0]    a_hi_r;
            logic [HI-CHUNK-1:0]    b_hi_r;
            logic [(k+1)*CHUNK-1:0] s_lo_r;
            logic                   c_r;

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    a_hi_r <= '0;
                    b_hi_r <= '0;
                    s_lo_r <= '0;
                    c_r    <= 1'b0;
                end else if (advance) begin
                    a_hi_r <= a_cur[HI-1:CHUNK];
                    b_hi_r <= b_cur[HI-1:CHUNK];
                    s_lo_r <= s_done;
                    c_r    <= sl_co;
                end
            end
        end else begin : g_fin
            assign fin_sum   = s_done;
            assign fin_co    = sl_co;
            assign fin_a_msb = a_cur[HI-1];
            assign fin_b_msb = b_cur[HI-1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stg_vld  <= '0;
            out_sum  <= '0;
            out_co   <= 1'b0;
            out_ovf  <= 1'b0;
            out_zero <= 1'b0;
        end else if (advance) begin
            stg_vld[0] <= accept;
            for (int i = 1; i < STAGES; i++) begin
                stg_vld[i] <= stg_vld[i-1];
            end
            out_sum  <= fin_sum;
            out_co   <= fin_co;
            out_ovf  <= (fin_a_msb == fin_b_msb) && (fin_sum[WIDTH-1] != fin_a_msb);
            out_zero <= (fin_sum == '0);
        end
    end

    assign out_valid = stg_vld[STAGES-1];

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed vectors, random handshake stream vs arithmetic model,
// mid-flight reset, and an exhaustive sweep of a 4-bit/1-bit-chunk instance.
module tb_pipe_add_sub;
    import add_sub_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        iv = 1'b0, ir, ov, orr = 1'b0;
    logic [31:0] a = '0, b = '0, sum;
    logic [1:0]  mode = '0;
    logic        cin = 1'b0, co, ovf, zero;

    logic        iv4 = 1'b0, ir4, ov4, orr4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic [1:0]  mode4 = '0;
    logic        cin4 = 1'b0, co4, ovf4, zero4;

    int tests = 0;
    int fails = 0;

    pipe_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b), .in_mode(mode), .in_cin(cin),
        .out_valid(ov), .out_ready(orr), .out_sum(sum), .out_co(co), .out_ovf(ovf), .out_zero(zero)
    );

    pipe_add_sub #(.WIDTH(4), .CHUNK(1)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_mode(mode4), .in_cin(cin4),
        .out_valid(ov4), .out_ready(orr4), .out_sum(sum4), .out_co(co4), .out_ovf(ovf4), .out_zero(zero4)
    );

    // Reference: true integer add/subtract; flags from unsigned range and signed range.
    function automatic res_t model(int w, longint ua, longint ub, logic [1:0] md, logic ci);
        longint m   = longint'(1) << w;
        longint sa  = (ua >= m / 2) ? ua - m : ua;
        longint sb  = (ub >= m / 2) ? ub - m : ub;
        longint cc  = ci ? 1 : 0;
        longint bor = ci ? 0 : 1;
        longint ur, sr;
        logic   c;
        res_t   r;
        case (md)
            ADD_MODE_ADD: begin ur = ua + ub;      sr = sa + sb;      c = (ur >= m); end
            ADD_MODE_ADC: begin ur = ua + ub + cc; sr = sa + sb + cc; c = (ur >= m); end
            ADD_MODE_SUB: begin ur = ua - ub;       sr = sa - sb;       c = (ur >= 0); end
            default:      begin ur = ua - ub - bor; sr = sa - sb - bor; c = (ur >= 0); end
        endcase
        r.sum  = 32'(ur & (m - 1));
        r.co   = c;
        r.ovf  = (sr < -(m / 2)) || (sr >= m / 2);
        r.zero = ((ur & (m - 1)) == 0);
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single beat into an empty pipe, entered and left at posedge+1.
    task automatic beat32(string tag, logic [31:0] ta, logic [31:0] tb_, logic [1:0] tm, logic tc,
                          res_t exp, int exp_lat);
        int lat;
        a = ta; b = tb_; mode = tm; cin = tc; iv = 1'b1; orr = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(ir), 64'd1);
        @(posedge clk); #1;
        iv = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_result"}, 64'({sum, co, ovf, zero}), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        res_t        e;
        res_t        q[$];
        logic [34:0] held;
        logic        stalled;
        logic        seen;
        int          acc, got, idx, first_acc, first_out;

        // Reset state
        orr4 = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(ir), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_outputs", 64'({sum, co, ovf, zero}), 64'd0);
        chk("rst_out_valid4", 64'(ov4), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors with literal expectations
        beat32("add_wrap", 32'hFFFF_FFFF, 32'h1, ADD_MODE_ADD, 1'b0, '{32'h0, 1'b1, 1'b0, 1'b1}, 4);
        beat32("sub_5_7", 32'd5, 32'd7, ADD_MODE_SUB, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}, 4);
        beat32("sub_ovf", 32'h8000_0000, 32'h1, ADD_MODE_SUB, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}, 4);
        beat32("add64_lo", 32'hFFFF_FFFF, 32'h1, ADD_MODE_ADD, 1'b1, '{32'h0, 1'b1, 1'b0, 1'b1}, 4);
        beat32("add64_hi", 32'h1, 32'h0, ADD_MODE_ADC, 1'b1, '{32'h2, 1'b0, 1'b0, 1'b0}, 4);
        beat32("sbb_borrow", 32'h0, 32'h0, ADD_MODE_SBB, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}, 4);

        // Random stream with random valid/ready
        acc = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            iv   = (acc < 1000) && ($urandom_range(0, 1) == 1);
            a    = $urandom;
            b    = $urandom;
            mode = 2'($urandom_range(0, 3));
            cin  = 1'($urandom_range(0, 1));
            orr  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stalled) chk("stall_hold", 64'({ov, sum, co, ovf, zero}), 64'({1'b1, held}));
            stalled = 1'b0;
            if (ov && orr) begin
                chk("rand_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rand_result", 64'({sum, co, ovf, zero}), 64'(e));
                    got++;
                end
            end else if (ov) begin
                chk("stall_in_ready", 64'(ir), 64'd0);
                held    = {sum, co, ovf, zero};
                stalled = 1'b1;
            end
            if (iv && ir) begin
                q.push_back(model(32, longint'(a), longint'(b), mode, cin));
                acc++;
            end
            @(posedge clk); #1;
        end
        iv = 1'b0; orr = 1'b1;
        chk("rand_delivered", 64'(got), 64'd1000);
        chk("rand_leftover", 64'(q.size()), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rand_no_extra", 64'(ov), 64'd0);
        @(posedge clk); #1;

        // Three beats in flight, then a one-cycle reset
        iv = 1'b1; mode = ADD_MODE_ADD;
        repeat (3) begin
            a = $urandom; b = $urandom;
            @(posedge clk); #1;
        end
        iv = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(ir), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(ov), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | ov;
        end
        chk("midrst_flushed", 64'(seen), 64'd0);
        @(posedge clk); #1;
        a = $urandom; b = $urandom;
        beat32("post_rst", a, b, ADD_MODE_SUB, 1'b0, model(32, longint'(a), longint'(b), ADD_MODE_SUB, 1'b0), 4);

        // Exhaustive sweep on the 4-bit instance
        q.delete();
        idx = 0; got = 0; first_acc = -1; first_out = -1;
        for (int cyc = 0; cyc < 2300 && got < 2048; cyc++) begin
            if (idx < 2048) begin
                {a4, b4, mode4, cin4} = 11'(idx);
                iv4 = 1'b1;
            end else begin
                iv4 = 1'b0;
            end
            @(negedge clk);
            if (ov4) begin
                if (first_out < 0) first_out = cyc;
                chk("exh_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("exh_result", 64'({28'b0, sum4, co4, ovf4, zero4}), 64'(e));
                    got++;
                end
            end
            if (iv4 && ir4) begin
                if (first_acc < 0) first_acc = cyc;
                q.push_back(model(4, longint'(a4), longint'(b4), mode4, cin4));
                idx++;
            end
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        chk("exh_count", 64'(got), 64'd2048);
        chk("exh_latency", 64'(first_out - first_acc), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
